// File: rtl/cache_defs_pkg.sv
// cache_defs: line-fill FSM encoding and widths shared with the cache controller
package cache_defs;
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2, RELEASE = 2'd3} lfu_state_e;
    localparam int Wn_Words          = 4;
    localparam int En_Data_W         = 32;
    localparam int En_Addr_W         = 32;
    localparam int Word_Select_Width = $clog2(Wn_Words);
endpackage

// File: rtl/lfu_word_cnt.sv
// lfu_word_cnt: wrap-around line word index with transfer count and last-word flag
module lfu_word_cnt #(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     adv,
    input  logic [$clog2(WORDS)-1:0] start,
    output logic [$clog2(WORDS)-1:0] idx,
    output logic                     last
);
    localparam int IW = $clog2(WORDS);
    logic [IW-1:0] idx_q, idx_d, cnt_q, cnt_d;
    always_comb begin
        idx_d = load ? start : adv ? idx_q + 1'b1 : idx_q;
        cnt_d = load ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end
    assign idx  = idx_q;
    assign last = &cnt_q;
endmodule

// File: rtl/line_fill_unit.sv
// line_fill_unit: cache line refill/write-back sequencer; LFU_CRITICAL_WORD_FIRST_EN starts refills at Word_Select
module line_fill_unit
    import cache_defs::*;
#(
    parameter int WORDS  = Wn_Words,
    parameter int DATA_W = En_Data_W,
    parameter int ADDR_W = En_Addr_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Req_Low,
    input  logic                     Wr_Low,
    input  logic [ADDR_W-1:0]        Line_Addr,
    input  logic [$clog2(WORDS)-1:0] Word_Select,
    input  logic [DATA_W-1:0]        WB_Data,
    output logic                     Rdy_Low,
    output logic                     Fill_We,
    output logic [$clog2(WORDS)-1:0] Fill_Word,
    output logic [DATA_W-1:0]        Fill_Data,
    output logic                     Mem_Req,
    output logic                     Mem_We,
    output logic [ADDR_W-1:0]        Mem_Addr,
    output logic [DATA_W-1:0]        Mem_WData,
    input  logic [DATA_W-1:0]        Mem_RData,
    input  logic                     Mem_Ack
);
    localparam int IW = $clog2(WORDS);
    localparam int BW = ADDR_W - IW - 2;
    lfu_state_e state_q, state_d;
    logic wr_q, wr_d;
    logic [BW-1:0] base_q, base_d;
    logic load, adv, last, xfer, unused_bits;
    logic [IW-1:0] idx, start;
`ifdef LFU_CRITICAL_WORD_FIRST_EN
    assign start       = Wr_Low ? '0 : Word_Select;
    assign unused_bits = ^Line_Addr[IW+1:0];
`else
    assign start       = '0;
    assign unused_bits = ^{Word_Select, Line_Addr[IW+1:0]};
`endif
    assign xfer = state_q == XFER;
    // An ack landing in a reset cycle must neither write the cache nor advance the burst
    always_comb begin
        load    = state_q == IDLE && Req_Low;
        adv     = xfer && Mem_Ack && !rst;
        wr_d    = load ? Wr_Low : wr_q;
        base_d  = load ? Line_Addr[ADDR_W-1:IW+2] : base_q;
        state_d = load ? XFER
                : (adv && last) ? DONE
                : state_q == DONE ? RELEASE
                : (state_q == RELEASE && !Req_Low) ? IDLE
                : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
        end
    end
    lfu_word_cnt #(.WORDS(WORDS)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .adv  (adv),
        .start(start),
        .idx  (idx),
        .last (last)
    );
    assign Rdy_Low   = state_q == DONE;
    assign Mem_Req   = xfer;
    assign Mem_We    = xfer && wr_q;
    assign Mem_Addr  = xfer ? {base_q, idx, 2'b00} : '0;
    assign Mem_WData = (xfer && wr_q) ? WB_Data : '0;
    assign Fill_We   = adv && !wr_q;
    assign Fill_Word = idx;
    assign Fill_Data = Fill_We ? Mem_RData : '0;
endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit: scoreboard bench for line_fill_unit
module tb_line_fill_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Req_Low = 1'b0, Wr_Low = 1'b0;
    logic [31:0] Line_Addr = '0;
    logic [1:0] Word_Select = '0;
    logic [31:0] WB_Data, Fill_Data, Mem_Addr, Mem_WData, Mem_RData;
    logic Rdy_Low, Fill_We, Mem_Req, Mem_We, Mem_Ack;
    logic [1:0] Fill_Word;
    logic ack_r = 1'b0, stray = 1'b0;
    int stall_left = 0;
    int n_chk = 0, n_pass = 0;

    typedef struct {bit rdy; bit wr; logic [31:0] addr; logic [31:0] data; logic [1:0] word;} ev_t;
    ev_t q[$];

    always #5 clk = ~clk;

    assign Mem_Ack   = ack_r | stray;
    assign Mem_RData = 32'hD000_0000 ^ Mem_Addr;
    assign WB_Data   = 32'hA0 + 32'(Fill_Word);

    line_fill_unit dut (
        .clk(clk), .rst(rst), .Req_Low(Req_Low), .Wr_Low(Wr_Low), .Line_Addr(Line_Addr),
        .Word_Select(Word_Select), .WB_Data(WB_Data), .Rdy_Low(Rdy_Low), .Fill_We(Fill_We),
        .Fill_Word(Fill_Word), .Fill_Data(Fill_Data), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // memory model: ack each request one cycle, idle one cycle, optional stall on word 1
    initial forever begin
        @(posedge clk);
        #1;
        if (rst || ack_r) ack_r = 1'b0;
        else if (Mem_Req) begin
            if (stall_left > 0 && Mem_Addr[3:2] == 2'd1) stall_left--;
            else ack_r = 1'b1;
        end
    end

    // monitor: pops the scoreboard on every memory transfer and Rdy_Low pulse
    initial begin
        bit pend;
        logic [31:0] pend_addr;
        ev_t e;
        pend = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                check("fill_we_in_rst", Fill_We, 0);
            end else begin
                check("fill_we_spur", Fill_We & ~(Mem_Req & Mem_Ack), 0);
                if (pend) begin
                    check("stall_req", Mem_Req, 1);
                    check("stall_addr", Mem_Addr, pend_addr);
                end
                if (Mem_Req && Mem_Ack) begin
                    check("xfer_expected", q.size() > 0 && !q[0].rdy, 1);
                    if (q.size() > 0 && !q[0].rdy) begin
                        e = q.pop_front();
                        check("mem_we", Mem_We, e.wr);
                        check("mem_addr", Mem_Addr, e.addr);
                        check("fill_word", Fill_Word, e.word);
                        check("fill_we", Fill_We, !e.wr);
                        if (e.wr) check("mem_wdata", Mem_WData, e.data);
                        else check("fill_data", Fill_Data, e.data);
                    end
                end
                if (Rdy_Low) begin
                    check("rdy_expected", q.size() > 0 && q[0].rdy, 1);
                    if (q.size() > 0 && q[0].rdy) e = q.pop_front();
                end
                pend = Mem_Req && !Mem_Ack;
                pend_addr = Mem_Addr;
            end
        end
    end

    task automatic push_word(input bit wr, input logic [31:0] base, input logic [1:0] w);
        ev_t e;
        e.rdy = 1'b0;
        e.wr = wr;
        e.word = w;
        e.addr = base + 32'(w) * 4;
        e.data = wr ? 32'hA0 + 32'(w) : 32'hD000_0000 ^ e.addr;
        q.push_back(e);
    endtask

    task automatic do_line(input bit wr, input logic [31:0] la, input logic [1:0] ws, input int hold);
        logic [1:0] st;
        logic [31:0] base;
        ev_t r;
        int t;
        base = la & 32'hFFFF_FFF0;
`ifdef LFU_CRITICAL_WORD_FIRST_EN
        st = wr ? 2'd0 : ws;
`else
        st = 2'd0;
`endif
        for (int i = 0; i < 4; i++) push_word(wr, base, st + 2'(i));
        r = '{rdy: 1'b1, wr: wr, addr: '0, data: '0, word: '0};
        q.push_back(r);
        @(posedge clk); #2;
        Req_Low = 1'b1; Wr_Low = wr; Line_Addr = la; Word_Select = ws;
        @(posedge clk); #2;
        Wr_Low = ~wr; Line_Addr = 32'hDEAD_BEEF; Word_Select = ~ws;
        t = 0;
        while (!Rdy_Low && t < 100) begin @(negedge clk); t++; end
        check("rdy_seen", Rdy_Low, 1);
        repeat (hold) @(posedge clk);
        @(posedge clk); #2;
        Req_Low = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", Rdy_Low, 0);
        check("rst_mem_req", Mem_Req, 0);
        check("rst_mem_we", Mem_We, 0);
        check("rst_fill_word", Fill_Word, 0);
        check("rst_mem_addr", Mem_Addr, 0);
        check("rst_mem_wdata", Mem_WData, 0);
        check("rst_fill_data", Fill_Data, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        do_line(1'b0, 32'h100, 2'd0, 0);
        do_line(1'b1, 32'h20F, 2'd3, 0);
        do_line(1'b0, 32'h100, 2'd2, 0);
        do_line(1'b0, 32'h400, 2'd1, 3);
        @(posedge clk); #2;
        stray = 1'b1;
        @(negedge clk);
        check("stray_mem_req", Mem_Req, 0);
        check("stray_rdy", Rdy_Low, 0);
        @(posedge clk); #2;
        stray = 1'b0;
        stall_left = 5;
        do_line(1'b0, 32'h500, 2'd0, 0);
        check("stall_consumed", stall_left, 0);
        push_word(1'b0, 32'h300, 2'd0);
        push_word(1'b0, 32'h300, 2'd1);
        @(posedge clk); #2;
        Req_Low = 1'b1; Wr_Low = 1'b0; Line_Addr = 32'h300; Word_Select = 2'd0;
        t = 0;
        while (!(Mem_Req && Mem_Addr == 32'h308) && t < 50) begin @(posedge clk); #2; t++; end
        check("rst_reach_w2", Mem_Addr, 32'h308);
        @(posedge clk); #2;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        Req_Low = 1'b0;
        @(negedge clk);
        check("mid_rst_req", Mem_Req, 0);
        check("mid_rst_fill_we", Fill_We, 0);
        check("mid_rst_fill_word", Fill_Word, 0);
        check("mid_rst_addr", Mem_Addr, 0);
        check("mid_rst_rdy", Rdy_Low, 0);
        repeat (2) @(posedge clk);
        do_line(1'b0, 32'h300, 2'd0, 0);
        repeat (4) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
